// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port data memory between the CPU
// MW stage and the UART buffer controller. The CPU has default priority;
// a UART request refused for UART_MAX_WAIT consecutive cycles is granted for
// one beat, stalling the CPU. Read returns are steered by a registered tag.
module dmem_arbiter #(
  parameter int UART_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // CPU port
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_mask,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  // UART buffer controller port
  input  logic        uart_req,
  input  logic        uart_we,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  output logic        uart_gnt,
  output logic        uart_rvalid,
  output logic [31:0] uart_rdata,
  // Memory command port
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACT  = 2'd1,
    UART_ACT = 2'd2
  } state_t;

  localparam logic [3:0] MAX_WAIT_CNT = 4'(UART_MAX_WAIT);
  localparam logic [3:0] WAIT_SAT     = 4'd15;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_next;
  logic        rd_pending;
  logic        force_uart;
  logic        cpu_gnt;

  // The UART is forced in once its refusal streak reaches the limit.
  assign force_uart = uart_req && (wait_cnt >= MAX_WAIT_CNT);

  // Pick the owner of this cycle's command, drive the memory from it and
  // compute the next owner and the next refusal-streak value.
  always_comb begin
    state_next    = IDLE;
    wait_cnt_next = wait_cnt;
    cpu_gnt       = 1'b0;
    uart_gnt      = 1'b0;
    cpu_stall     = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;
    mem_mask      = 4'd0;

    // Nothing is granted while reset is held, so the first grant lands on
    // the first edge after release.
    if (rst) begin
      if (uart_req && (force_uart || !cpu_req)) begin
        uart_gnt   = 1'b1;
        state_next = UART_ACT;
        mem_en     = 1'b1;
        mem_we     = uart_we;
        mem_addr   = uart_addr;
        mem_wdata  = uart_wdata;
        mem_mask   = 4'b1111;
      end else if (cpu_req) begin
        cpu_gnt    = 1'b1;
        state_next = CPU_ACT;
        mem_en     = 1'b1;
        mem_we     = cpu_we;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_mask   = cpu_mask;
      end

      // The streak clears on a grant or when the UART gives up, and
      // otherwise counts refused cycles up to saturation.
      if (uart_gnt || !uart_req) begin
        wait_cnt_next = 4'd0;
      end else if (wait_cnt != WAIT_SAT) begin
        wait_cnt_next = wait_cnt + 4'd1;
      end

      cpu_stall = cpu_req && !cpu_gnt;
    end
  end

  // Owner register, refusal streak and the "last command was a read" tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      rd_pending <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      rd_pending <= mem_en && !mem_we;
    end
  end

  // Read data returns to whoever owned last cycle's read; the tag is cleared
  // by reset, which also cancels any pending return.
  assign cpu_rvalid  = rd_pending && (state == CPU_ACT);
  assign uart_rvalid = rd_pending && (state == UART_ACT);
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : 32'd0;
  assign uart_rdata  = uart_rvalid ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by a
// randomized run, all checked against a cycle-level behavioural model.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_mask;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        uart_req;
  logic        uart_we;
  logic [31:0] uart_addr;
  logic [31:0] uart_wdata;
  logic        uart_gnt;
  logic        uart_rvalid;
  logic [31:0] uart_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;

  int passCount  = 0;
  int checkCount = 0;

  // Model state: length of the UART's current refusal streak and the owners
  // of reads still waiting for their data (1 = CPU, 2 = UART).
  int refused = 0;
  int readQ[$];

  dmem_arbiter #(.UART_MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_mask   (cpu_mask),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .uart_req   (uart_req),
    .uart_we    (uart_we),
    .uart_addr  (uart_addr),
    .uart_wdata (uart_wdata),
    .uart_gnt   (uart_gnt),
    .uart_rvalid(uart_rvalid),
    .uart_rdata (uart_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_mask   (mem_mask),
    .mem_rdata  (mem_rdata)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic r, input logic cr, input logic cw,
                               input logic [31:0] ca, input logic [31:0] cwd,
                               input logic [3:0] cm, input logic ur, input logic uw,
                               input logic [31:0] ua, input logic [31:0] uwd,
                               input logic [31:0] mrd);
    rst        = r;
    cpu_req    = cr;
    cpu_we     = cw;
    cpu_addr   = ca;
    cpu_wdata  = cwd;
    cpu_mask   = cm;
    uart_req   = ur;
    uart_we    = uw;
    uart_addr  = ua;
    uart_wdata = uwd;
    mem_rdata  = mrd;
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  // across the coming clock edge.
  task automatic checkOutput();
    int   due;
    logic forced;
    logic uartWins;
    logic cpuWins;
    due = 0;
    if (readQ.size() > 0) due = readQ.pop_front();

    if (!rst) begin
      readQ.delete();
      refused = 0;
      check("rst_cpu_stall",   {31'd0, cpu_stall},   32'd0);
      check("rst_uart_gnt",    {31'd0, uart_gnt},    32'd0);
      check("rst_mem_en",      {31'd0, mem_en},      32'd0);
      check("rst_cpu_rvalid",  {31'd0, cpu_rvalid},  32'd0);
      check("rst_uart_rvalid", {31'd0, uart_rvalid}, 32'd0);
      check("rst_cpu_rdata",   cpu_rdata,            32'd0);
      check("rst_uart_rdata",  uart_rdata,           32'd0);
      return;
    end

    forced   = uart_req && (refused >= MAX_WAIT);
    uartWins = uart_req && (forced || !cpu_req);
    cpuWins  = cpu_req && !uartWins;

    check("cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req && !cpuWins});
    check("uart_gnt",  {31'd0, uart_gnt},  {31'd0, uartWins});
    check("mem_en",    {31'd0, mem_en},    {31'd0, cpuWins || uartWins});
    if (cpuWins) begin
      check("cpu_mem_we",    {31'd0, mem_we}, {31'd0, cpu_we});
      check("cpu_mem_addr",  mem_addr,        cpu_addr);
      check("cpu_mem_wdata", mem_wdata,       cpu_wdata);
      check("cpu_mem_mask",  {28'd0, mem_mask}, {28'd0, cpu_mask});
    end
    if (uartWins) begin
      check("uart_mem_we",    {31'd0, mem_we}, {31'd0, uart_we});
      check("uart_mem_addr",  mem_addr,        uart_addr);
      check("uart_mem_wdata", mem_wdata,       uart_wdata);
      check("uart_mem_mask",  {28'd0, mem_mask}, 32'h0000000F);
    end

    check("cpu_rvalid",  {31'd0, cpu_rvalid},  {31'd0, due == 1});
    check("uart_rvalid", {31'd0, uart_rvalid}, {31'd0, due == 2});
    if (due == 1) check("cpu_rdata",  cpu_rdata,  mem_rdata);
    if (due == 2) check("uart_rdata", uart_rdata, mem_rdata);

    if (uartWins)      refused = 0;
    else if (uart_req) refused = (refused >= 15) ? 15 : refused + 1;
    else               refused = 0;

    if (cpuWins && !cpu_we)   readQ.push_back(1);
    if (uartWins && !uart_we) readQ.push_back(2);
  endtask

  task automatic runCycle(input logic r, input logic cr, input logic cw,
                          input logic [31:0] ca, input logic [31:0] cwd,
                          input logic [3:0] cm, input logic ur, input logic uw,
                          input logic [31:0] ua, input logic [31:0] uwd,
                          input logic [31:0] mrd);
    applyStimulus(r, cr, cw, ca, cwd, cm, ur, uw, ua, uwd, mrd);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input logic [31:0] mrd);
    runCycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, mrd);
  endtask

  initial begin
    logic        cr;
    logic        ur;
    logic        r;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with both sides requesting: everything stays quiet.
    runCycle(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 4'hF, 1'b1, 1'b0, 32'h200, 32'd0, 32'h11111111);
    runCycle(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 4'hF, 1'b1, 1'b0, 32'h200, 32'd0, 32'h22222222);

    // CPU load of 0x100 granted on the first cycle after release.
    runCycle(1'b1, 1'b1, 1'b0, 32'h100, 32'd0, 4'hF, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    idleCycle(32'hDEADBEEF);

    // Both held: four CPU grants, one forced UART beat, then CPU again.
    for (int i = 0; i < 11; i++)
      runCycle(1'b1, 1'b1, 1'b1, 32'h300 + 32'(i), 32'hA0 + 32'(i), 4'b0011,
               1'b1, 1'b1, 32'h400, 32'h77, 32'd0);
    idleCycle(32'd0);

    // UART-only store.
    runCycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 32'h200, 32'h55, 32'd0);
    idleCycle(32'h0BADF00D);

    // CPU reads followed back-to-back by a forced UART read.
    for (int i = 0; i < 5; i++)
      runCycle(1'b1, 1'b1, 1'b0, 32'h500 + 32'(4 * i), 32'd0, 4'hF,
               1'b1, 1'b0, 32'h600, 32'd0, 32'hC0DE0000 + 32'(i));
    runCycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hCAFE0005);
    idleCycle(32'hCAFE0006);

    // Reset pulled low the cycle after a CPU read grant cancels the return.
    runCycle(1'b1, 1'b1, 1'b0, 32'h700, 32'd0, 4'hF, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    runCycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h12345678);
    idleCycle(32'h87654321);
    idleCycle(32'h87654321);

    // UART drops after three refusals; the streak restarts from zero.
    for (int i = 0; i < 3; i++)
      runCycle(1'b1, 1'b1, 1'b1, 32'h800, 32'd1, 4'hF, 1'b1, 1'b1, 32'h900, 32'd2, 32'd0);
    runCycle(1'b1, 1'b1, 1'b1, 32'h800, 32'd1, 4'hF, 1'b0, 1'b1, 32'h900, 32'd2, 32'd0);
    for (int i = 0; i < 6; i++)
      runCycle(1'b1, 1'b1, 1'b1, 32'h800, 32'd1, 4'hF, 1'b1, 1'b1, 32'h900, 32'd2, 32'd0);
    idleCycle(32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 63) != 0);
      cr = ($urandom_range(0, 3) != 0);
      ur = ($urandom_range(0, 3) != 0);
      runCycle(r, cr, 1'($urandom), $urandom, $urandom, 4'($urandom),
               ur, 1'($urandom), $urandom, $urandom, $urandom);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter UART_MAX_WAIT, default 4, is the number of consecutive cycles a UART request may be refused before it is force-granted (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 cpu_req  input  1  MW-stage load/store request.
REQ-005 cpu_we  input  1  1 = store, 0 = load.
REQ-006 cpu_addr  input  32  CPU byte address.
REQ-007 cpu_wdata  input  32  CPU store data.
REQ-008 cpu_mask  input  4  CPU byte-enable.
REQ-009 cpu_stall  output  1  freeze pipeline; CPU request not served this cycle.
REQ-010 cpu_rvalid  output  1  one-cycle pulse, cpu_rdata valid.
REQ-011 cpu_rdata  output  32  CPU load data.
REQ-012 uart_req  input  1  UART buffer controller request, held until granted.
REQ-013 uart_we, uart_addr, uart_wdata  input  1/32/32  UART access fields; byte-enable always 4'b1111.
REQ-014 uart_gnt  output  1  one-cycle pulse, UART access issued this cycle.
REQ-015 uart_rvalid, uart_rdata  output  1/32  UART read return.
REQ-016 mem_en, mem_we, mem_addr, mem_wdata, mem_mask  output  1/1/32/32/4  single-port data memory command.
REQ-017 mem_rdata  input  32  memory read data, valid the cycle after a read command.

Function
REQ-018 The arbiter SHALL issue at most one memory command per cycle; commands are driven combinationally from the granted requester.
REQ-019 State machine SHALL have states IDLE, CPU_ACT, UART_ACT recording the owner of the previous cycle's command.
REQ-020 Default priority SHALL be CPU: if cpu_req=1 and the force condition is false, the CPU is granted, cpu_stall=0, next state CPU_ACT.
REQ-021 If only uart_req=1, the UART is granted, uart_gnt=1, next state UART_ACT.
REQ-022 If neither is requesting, mem_en=0, next state IDLE.
REQ-023 A 4-bit wait counter SHALL increment each cycle uart_req=1 and uart_gnt=0, saturate at 15, and clear on uart_gnt.
REQ-024 Force condition: wait counter >= UART_MAX_WAIT; when true and uart_req=1, the UART SHALL be granted even if cpu_req=1, with cpu_stall=1 that cycle.
REQ-025 A force grant SHALL be a single beat; the following cycle returns to CPU priority.
REQ-026 cpu_stall SHALL equal cpu_req AND NOT (CPU granted this cycle); it is never asserted when cpu_req=0.
REQ-027 For a granted read, the requester's rvalid SHALL pulse exactly one cycle after the grant, with rdata = mem_rdata; the owner is tracked by a registered read-tag, not by the current grant.
REQ-028 Back-to-back reads from different owners SHALL return data to the correct owner in issue order.
REQ-029 Stores SHALL produce no rvalid pulse; CPU stores use cpu_mask, UART stores use 4'b1111.
REQ-030 Simultaneous first-cycle cpu_req and uart_req with the counter at 0 SHALL grant the CPU and increment the counter to 1.
REQ-031 Requests deasserted without a grant SHALL leave the counter unchanged only if uart_req falls; a fallen uart_req SHALL clear the counter.

Reset
REQ-032 While rst=0: state IDLE, counter 0, read-tag cleared, cpu_rvalid=0, uart_rvalid=0, uart_gnt=0, mem_en=0, cpu_stall=0, cpu_rdata=0, uart_rdata=0.
REQ-033 Reset asserted mid-read SHALL cancel the pending rvalid; no pulse follows reset release.
REQ-034 The first grant after reset release SHALL occur in the first posedge with rst=1.

Verification
REQ-035 CPU load addr 0x100, memory returns 0xDEADBEEF -> cpu_stall=0, cpu_rvalid pulse next cycle, cpu_rdata=0xDEADBEEF.
REQ-036 cpu_req and uart_req held continuously, UART_MAX_WAIT=4 -> CPU granted 4 cycles, 5th cycle uart_gnt=1 and cpu_stall=1, 6th cycle CPU granted, counter 0.
REQ-037 UART-only store addr 0x200 data 0x55 -> mem_we=1, mem_mask=4'b1111, uart_gnt=1, no rvalid.
REQ-038 CPU read then forced UART read back-to-back -> cpu_rvalid then uart_rvalid on consecutive cycles with the respective data.
REQ-039 rst pulled low the cycle after a CPU read grant -> no cpu_rvalid, all outputs 0, state IDLE after release.
REQ-040 uart_req dropped after 3 refused cycles then reasserted -> counter restarts at 0; force occurs only after 4 more refused cycles.
